// File: rtl/nileswan_buf_pkg.sv
// Shared definitions for the 2 KiB byte-write / halfword-read buffer RAM.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nileswan_buf_pkg;

  localparam int BUF_ADDR_W = 11;
  localparam int BUF_BYTES  = 2048;

  // Receive-writer transfer state.
  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE
  } rxw_state_t;

endpackage

// File: rtl/spi_byte_shifter.sv
// Purpose: collects MSB-first serial bits into bytes; ByteValid pulses with the 8th bit.
// Latency: combinational ByteData/ByteValid in the cycle of the 8th accepted strobe.
// Backpressure: none; strobes are only taken while Enable=1, Clear discards a partial byte.
// Ports:
//   Clk, Reset           clock, synchronous active-high reset
//   Clear                drop any partial byte and restart at bit 0
//   Enable               accept BitStrobe this cycle
//   BitStrobe, SerData   serial bit strobe and its data
//   ByteData, ByteValid  assembled byte and its 1-cycle qualifier
module spi_byte_shifter (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Clear,
  input  logic       Enable,
  input  logic       BitStrobe,
  input  logic       SerData,
  output logic [7:0] ByteData,
  output logic       ByteValid
);

  // Only the seven earlier bits need storage; the 8th comes straight from SerData.
  logic [6:0] shift_q;
  logic [2:0] bitcnt_q;
  logic       take;

  assign take      = Enable && BitStrobe;
  assign ByteData  = {shift_q, SerData};
  assign ByteValid = take && (bitcnt_q == 3'd7);

  always_ff @(posedge Clk) begin
    if (Reset || Clear) begin
      shift_q  <= '0;
      bitcnt_q <= '0;
    end else if (take) begin
      shift_q  <= {shift_q[5:0], SerData};
      bitcnt_q <= bitcnt_q + 3'd1;
    end
  end

endmodule

// File: rtl/spi_rx_buffer_writer.sv
// Purpose: deserialises a strobed MSB-first bit stream into byte writes for the buffer RAM,
//          over a host-programmed transfer (start address + length) with Done/Abort signalling.
// Latency: write appears 1 cycle after the 8th bit strobe; Done 1 cycle after the last write.
// Backpressure: none; the RAM port always accepts, strobes outside an active transfer are dropped.
// Ports:
//   Clk, Reset                  clock, synchronous active-high reset
//   Start, StartAddr, Length    begin transfer at StartAddr for Length+1 bytes (IDLE only)
//   Abort                       cancel transfer, beats everything but Reset
//   BitStrobe, SerData          serial input bit stream
//   Busy, Done, BytesWritten    transfer status
//   WriteEnable/Addr/Data       RAM byte write port
module spi_rx_buffer_writer
  import nileswan_buf_pkg::*;
#(
  parameter int ADDR_W = BUF_ADDR_W,
  parameter int DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] StartAddr,
  input  logic [ADDR_W-1:0] Length,
  input  logic              Abort,
  input  logic              BitStrobe,
  input  logic              SerData,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W:0]   BytesWritten,
  output logic              WriteEnable,
  output logic [ADDR_W-1:0] WriteAddr,
  output logic [DATA_W-1:0] WriteData
);

  rxw_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] remaining_q;   // bytes still to write after the current one
  logic              start_acc;
  logic              last_write;
  logic              shift_en;
  logic              shift_clr;
  logic [7:0]        byte_dat;
  logic              byte_vld;

  assign start_acc  = (state_q == IDLE) && Start && !Abort;
  // The write now on the port is the final one of the transfer.
  assign last_write = (state_q == RECV) && WriteEnable && (remaining_q == '0);
  // Strobes stop counting from the final write cycle onward.
  assign shift_en   = (state_q == RECV) && !last_write;
  assign shift_clr  = start_acc || Abort;

  spi_byte_shifter u_shifter (
    .Clk       (Clk),
    .Reset     (Reset),
    .Clear     (shift_clr),
    .Enable    (shift_en),
    .BitStrobe (BitStrobe),
    .SerData   (SerData),
    .ByteData  (byte_dat),
    .ByteValid (byte_vld)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    Busy    = 1'b0;
    Done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = RECV;
        end
      end
      RECV: begin
        Busy = 1'b1;
        if (last_write) begin
          state_d = DONE;
        end
      end
      DONE: begin
        Done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (Abort) begin
      state_d = IDLE;
    end
  end

  // Write register stage plus address / count bookkeeping. Counters advance at the
  // end of each write cycle, so a write already on the port completes even if Abort
  // arrives alongside it; an Abort alongside the 8th strobe suppresses the write.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      WriteEnable  <= 1'b0;
      WriteAddr    <= '0;
      WriteData    <= '0;
      addr_q       <= '0;
      remaining_q  <= '0;
      BytesWritten <= '0;
    end else begin
      WriteEnable <= byte_vld && !Abort;
      if (byte_vld && !Abort) begin
        WriteData <= DATA_W'(byte_dat);
        WriteAddr <= addr_q;
      end
      if (WriteEnable) begin
        addr_q       <= addr_q + ADDR_W'(1);
        remaining_q  <= remaining_q - ADDR_W'(1);
        BytesWritten <= BytesWritten + (ADDR_W + 1)'(1);
      end
      if (start_acc) begin
        addr_q       <= StartAddr;
        remaining_q  <= Length;
        BytesWritten <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spi_rx_buffer_writer.sv
// Bench for spi_rx_buffer_writer: transaction-level model compared every cycle,
// plus literal checks on addresses, data, latency, counts and Done pulses.
// Latency/backpressure: n/a.
module tb_spi_rx_buffer_writer;
  import nileswan_buf_pkg::*;

  localparam int AW = BUF_ADDR_W;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Start = 1'b0;
  logic          Abort = 1'b0;
  logic          BitStrobe = 1'b0;
  logic          SerData = 1'b0;
  logic [AW-1:0] StartAddr = '0;
  logic [AW-1:0] Length = '0;
  logic          Busy, Done, WriteEnable;
  logic [AW:0]   BytesWritten;
  logic [AW-1:0] WriteAddr;
  logic [7:0]    WriteData;

  spi_rx_buffer_writer dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr), .Length(Length),
    .Abort(Abort), .BitStrobe(BitStrobe), .SerData(SerData), .Busy(Busy), .Done(Done),
    .BytesWritten(BytesWritten), .WriteEnable(WriteEnable), .WriteAddr(WriteAddr),
    .WriteData(WriteData)
  );

  initial forever #5 Clk = ~Clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int log_addr[$];
  int log_data[$];
  int log_cyc[$];
  int t8q[$];

  // Transaction-level model: expected port values for the current cycle.
  bit m_run = 0;   // accepting bits
  bit m_last = 0;  // final byte write is on the port this cycle
  int m_nbits = 0, m_acc = 0, m_addr = 0, m_left = 0;
  int e_busy = 0, e_done = 0, e_we = 0, e_addr = 0, e_data = 0, e_bw = 0;

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic model_step();
    int n_we;
    int n_done;
    n_we   = 0;
    n_done = 0;
    if (Reset) begin
      m_run = 0; m_last = 0; m_nbits = 0; m_acc = 0; m_addr = 0; m_left = 0;
      e_busy = 0; e_addr = 0; e_data = 0; e_bw = 0;
    end else begin
      if (e_we != 0) e_bw++;
      if (Abort) begin
        m_run = 0; m_last = 0; m_nbits = 0; m_acc = 0; e_busy = 0;
      end else if (m_last) begin
        m_last = 0; e_busy = 0; n_done = 1;
      end else if (e_busy == 0 && e_done == 0 && Start) begin
        m_run = 1; m_nbits = 0; m_acc = 0;
        m_addr = int'(StartAddr); m_left = int'(Length) + 1;
        e_bw = 0; e_busy = 1;
      end else if (m_run && BitStrobe) begin
        m_acc = ((m_acc << 1) | int'(SerData)) & 255;
        m_nbits++;
        if (m_nbits == 8) begin
          m_nbits = 0;
          n_we   = 1;
          e_addr = m_addr;
          e_data = m_acc;
          m_addr = (m_addr + 1) % BUF_BYTES;
          m_left--;
          if (m_left == 0) begin
            m_run  = 0;
            m_last = 1;
          end
        end
      end
    end
    e_we   = n_we;
    e_done = n_done;
  endtask

  initial forever begin
    @(posedge Clk);
    cyc++;
    model_step();
  end

  // Compare and log process, away from the active edge.
  initial forever begin
    @(negedge Clk);
    check("busy", int'(Busy), e_busy);
    check("done", int'(Done), e_done);
    check("bytes_written", int'(BytesWritten), e_bw);
    check("write_enable", int'(WriteEnable), e_we);
    check("write_addr", int'(WriteAddr), e_addr);
    check("write_data", int'(WriteData), e_data);
    if (WriteEnable) begin
      log_addr.push_back(int'(WriteAddr));
      log_data.push_back(int'(WriteData));
      log_cyc.push_back(cyc);
    end
    if (Done) done_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drv(input logic st, input logic ab, input logic bs, input logic sd);
    Start = st; Abort = ab; BitStrobe = bs; SerData = sd;
    @(negedge Clk);
    Start = 1'b0; Abort = 1'b0; BitStrobe = 1'b0; SerData = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drv(0, 0, 0, 0);
  endtask

  task automatic do_start(input int a, input int l);
    StartAddr = AW'(a);
    Length    = AW'(l);
    drv(1, 0, 0, 0);
  endtask

  // Sends the top nbits of b, MSB first, with gap idle cycles after each strobe.
  task automatic send_byte(input logic [7:0] b, input int gap, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      if (i == 0) t8q.push_back(cyc);
      drv(0, 0, 1, b[i]);
      idle(gap);
    end
  endtask

  task automatic clear_logs();
    log_addr.delete(); log_data.delete(); log_cyc.delete(); t8q.delete();
  endtask

  int d0;
  logic [7:0] pat;

  initial begin
    repeat (3) @(negedge Clk);
    check("rst_busy", int'(Busy), 0);
    check("rst_bytes_written", int'(BytesWritten), 0);
    Reset = 1'b0;
    idle(2);

    // 1: reset in the middle of a transfer, then strobes while idle
    clear_logs();
    do_start(12'h040, 5);
    send_byte(8'h5A, 0, 8);
    send_byte(8'hF0, 0, 5);
    Reset = 1'b1;
    @(negedge Clk);
    check("t1_busy", int'(Busy), 0);
    check("t1_we", int'(WriteEnable), 0);
    check("t1_bw", int'(BytesWritten), 0);
    check("t1_addr", int'(WriteAddr), 0);
    check("t1_data", int'(WriteData), 0);
    Reset = 1'b0;
    send_byte(8'hFF, 0, 8);
    idle(3);
    check("t1_writes", log_addr.size(), 1);

    // 2: two bytes, one strobe every other cycle
    clear_logs();
    d0 = done_cnt;
    do_start(12'h010, 1);
    send_byte(8'hA5, 1, 8);
    send_byte(8'h3C, 1, 8);
    idle(4);
    check("t2_writes", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      check("t2_addr0", log_addr[0], 12'h010);
      check("t2_data0", log_data[0], 8'hA5);
      check("t2_addr1", log_addr[1], 12'h011);
      check("t2_data1", log_data[1], 8'h3C);
      check("t2_lat0", log_cyc[0] - t8q[0], 1);
      check("t2_lat1", log_cyc[1] - t8q[1], 1);
    end
    check("t2_done", done_cnt - d0, 1);
    check("t2_bw", int'(BytesWritten), 2);

    // 3: address wrap at the top of the buffer
    clear_logs();
    do_start(12'h7FF, 2);
    send_byte(8'h11, 2, 8);
    send_byte(8'h22, 2, 8);
    send_byte(8'h33, 2, 8);
    idle(4);
    check("t3_writes", log_addr.size(), 3);
    if (log_addr.size() == 3) begin
      check("t3_addr0", log_addr[0], 12'h7FF);
      check("t3_addr1", log_addr[1], 12'h000);
      check("t3_addr2", log_addr[2], 12'h001);
      check("t3_data2", log_data[2], 8'h33);
    end

    // 4: strobes every cycle, 32 bits
    clear_logs();
    do_start(12'h200, 3);
    send_byte(8'hDE, 0, 8);
    send_byte(8'hAD, 0, 8);
    send_byte(8'hBE, 0, 8);
    send_byte(8'hEF, 0, 8);
    idle(4);
    check("t4_writes", log_addr.size(), 4);
    if (log_addr.size() == 4) begin
      check("t4_data0", log_data[0], 8'hDE);
      check("t4_data1", log_data[1], 8'hAD);
      check("t4_data2", log_data[2], 8'hBE);
      check("t4_data3", log_data[3], 8'hEF);
      for (int i = 1; i < 4; i++) check("t4_spacing", log_cyc[i] - log_cyc[i-1], 8);
    end
    check("t4_bw", int'(BytesWritten), 4);

    // 5: abort after one byte and five bits, then restart at once
    clear_logs();
    d0 = done_cnt;
    do_start(12'h300, 5);
    send_byte(8'hC3, 0, 8);
    send_byte(8'hF0, 0, 5);
    drv(0, 1, 0, 0);
    check("t5_busy", int'(Busy), 0);
    check("t5_bw", int'(BytesWritten), 1);
    do_start(12'h305, 0);
    check("t5_restart_busy", int'(Busy), 1);
    check("t5_done_none", done_cnt - d0, 0);
    check("t5_writes_before", log_addr.size(), 1);
    send_byte(8'h77, 0, 8);
    idle(4);
    check("t5_writes", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      check("t5_addr1", log_addr[1], 12'h305);
      check("t5_data1", log_data[1], 8'h77);
    end
    check("t5_done", done_cnt - d0, 1);

    // 6: strobes while idle, Start while busy, then a full 2048-byte transfer
    clear_logs();
    d0 = done_cnt;
    send_byte(8'hFF, 0, 3);
    do_start(12'h123, 2047);
    do_start(12'h400, 0);
    for (int i = 0; i < BUF_BYTES; i++) begin
      pat = 8'((i * 37 + 5) & 255);
      send_byte(pat, 0, 8);
    end
    idle(4);
    check("t6_writes", log_addr.size(), 2048);
    if (log_addr.size() == 2048) begin
      check("t6_addr_first", log_addr[0], 12'h123);
      check("t6_addr_second", log_addr[1], 12'h124);
      check("t6_addr_last", log_addr[2047], 12'h122);
      check("t6_data_first", log_data[0], 5);
      check("t6_data_last", log_data[2047], (2047 * 37 + 5) & 255);
    end
    check("t6_bw", int'(BytesWritten), 2048);
    check("t6_done", done_cnt - d0, 1);
    check("t6_busy", int'(Busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
